// File: rtl/pcie_dllp_sched.sv
// DLL receive-side DLLP scheduler: coalesces Acks, raises one Nak per error episode and
// refreshes UpdateFC credits, issuing one DLLP at a time on a valid/ready link.
module pcie_dllp_sched #(
  parameter int SEQ_W         = 12,
  parameter int ACK_TIMER_MAX = 64,
  parameter int ACK_COALESCE  = 4,
  parameter int FC_TIMER_MAX  = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             dl_active_i,
  input  logic             tlp_good_i,
  input  logic [SEQ_W-1:0] tlp_seq_i,
  input  logic             tlp_bad_i,
  input  logic [2:0]       fc_upd_req_i,
  input  logic [23:0]      fc_hdr_i,
  input  logic [35:0]      fc_data_i,
  output logic             dllp_valid_o,
  input  logic             dllp_ready_i,
  output logic [7:0]       dllp_type_o,
  output logic [23:0]      dllp_payload_o
);
  localparam int ACK_LIM   = (ACK_TIMER_MAX > 0) ? ACK_TIMER_MAX - 1 : 0;
  localparam int ACK_TMR_W = (ACK_LIM > 0) ? $clog2(ACK_LIM + 1) : 1;
  localparam int CNT_W     = (ACK_COALESCE > 0) ? $clog2(ACK_COALESCE + 1) : 1;
  localparam int FC_W      = (FC_TIMER_MAX > 1) ? $clog2(FC_TIMER_MAX) : 1;

  localparam logic [7:0] TYPE_ACK    = 8'h00;
  localparam logic [7:0] TYPE_NAK    = 8'h10;
  localparam logic [7:0] TYPE_FC_P   = 8'h80;
  localparam logic [7:0] TYPE_FC_NP  = 8'h90;
  localparam logic [7:0] TYPE_FC_CPL = 8'hA0;

  typedef enum logic {IDLE, SEND} state_t;
  state_t state, state_next;

  logic [SEQ_W-1:0]     ackd_seq;
  logic                 ack_pend;
  logic [CNT_W-1:0]     good_cnt;
  logic [ACK_TMR_W-1:0] ack_tmr;
  logic                 nak_req;
  logic                 nak_sched;
  logic [2:0]           fc_pend;
  logic [FC_W-1:0]      fc_tmr;

  logic                 ack_elig;
  logic                 can_load;
  logic                 load_nak;
  logic                 load_ack;
  logic [2:0]           load_fc;
  logic                 load_any;
  logic                 ack_clr;
  logic                 nak_set;
  logic                 fc_wrap;
  logic [7:0]           type_next;
  logic [23:0]          payload_next;
  logic [CNT_W-1:0]     good_cnt_inc;
  logic [ACK_TMR_W-1:0] ack_tmr_inc;

  function automatic logic [23:0] fc_payload(input logic [7:0] hdr, input logic [11:0] data);
    return {2'b00, hdr, 2'b00, data};
  endfunction

  // Both counters saturate so a long stall on the link cannot wrap them back to ineligible.
  assign good_cnt_inc = (good_cnt == CNT_W'(ACK_COALESCE)) ? good_cnt : good_cnt + CNT_W'(1);
  assign ack_tmr_inc  = (ack_tmr == ACK_TMR_W'(ACK_LIM)) ? ack_tmr : ack_tmr + ACK_TMR_W'(1);
  assign fc_wrap      = (fc_tmr == FC_W'(FC_TIMER_MAX - 1));
  assign dllp_valid_o = (state == SEND);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    load_nak     = 1'b0;
    load_ack     = 1'b0;
    load_fc      = 3'b000;
    type_next    = dllp_type_o;
    payload_next = dllp_payload_o;
    state_next   = state;

    ack_elig = ack_pend && ((ack_tmr >= ACK_TMR_W'(ACK_LIM)) ||
                            (good_cnt >= CNT_W'(ACK_COALESCE)));
    can_load = dl_active_i && ((state == IDLE) || dllp_ready_i);

    if (can_load) begin
      if (nak_req) begin
        load_nak     = 1'b1;
        type_next    = TYPE_NAK;
        payload_next = 24'(ackd_seq);
      end else if (ack_elig) begin
        load_ack     = 1'b1;
        type_next    = TYPE_ACK;
        payload_next = 24'(ackd_seq);
      end else if (fc_pend[0]) begin
        load_fc      = 3'b001;
        type_next    = TYPE_FC_P;
        payload_next = fc_payload(fc_hdr_i[7:0], fc_data_i[11:0]);
      end else if (fc_pend[1]) begin
        load_fc      = 3'b010;
        type_next    = TYPE_FC_NP;
        payload_next = fc_payload(fc_hdr_i[15:8], fc_data_i[23:12]);
      end else if (fc_pend[2]) begin
        load_fc      = 3'b100;
        type_next    = TYPE_FC_CPL;
        payload_next = fc_payload(fc_hdr_i[23:16], fc_data_i[35:24]);
      end
    end

    load_any = load_nak || load_ack || (load_fc != 3'b000);
    // A Nak carries ackd_seq, so it acknowledges everything an Ack would have.
    ack_clr  = load_nak || load_ack;
    nak_set  = tlp_bad_i && !tlp_good_i && !nak_sched;

    case (state)
      IDLE:    if (load_any) state_next = SEND;
      SEND:    if (dllp_ready_i) state_next = load_any ? SEND : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dllp_type_o    <= 8'h00;
      dllp_payload_o <= 24'h000000;
    end else if (load_any) begin
      dllp_type_o    <= type_next;
      dllp_payload_o <= payload_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ackd_seq  <= '1;
      ack_pend  <= 1'b0;
      good_cnt  <= '0;
      ack_tmr   <= '0;
      nak_req   <= 1'b0;
      nak_sched <= 1'b0;
      fc_pend   <= 3'b000;
      fc_tmr    <= '0;
    end else if (!dl_active_i) begin
      ack_pend  <= 1'b0;
      good_cnt  <= '0;
      ack_tmr   <= '0;
      nak_req   <= 1'b0;
      nak_sched <= 1'b0;
      fc_pend   <= 3'b000;
      fc_tmr    <= '0;
    end else begin
      // A new good TLP arriving with its own Ack/Nak load restarts the pending Ack.
      if (tlp_good_i) begin
        ackd_seq  <= tlp_seq_i;
        ack_pend  <= 1'b1;
        nak_sched <= 1'b0;
        good_cnt  <= ack_clr ? CNT_W'(1) : good_cnt_inc;
        ack_tmr   <= ack_clr ? '0 : (ack_pend ? ack_tmr_inc : ack_tmr);
      end else if (ack_clr) begin
        ack_pend <= 1'b0;
        good_cnt <= '0;
        ack_tmr  <= '0;
      end else if (ack_pend) begin
        ack_tmr <= ack_tmr_inc;
      end

      nak_req <= (nak_req && !load_nak) || nak_set;
      if (nak_set) nak_sched <= 1'b1;

      fc_pend <= (fc_pend & ~load_fc) | fc_upd_req_i | {3{fc_wrap}};
      fc_tmr  <= fc_wrap ? '0 : fc_tmr + FC_W'(1);
    end
  end

endmodule

// File: tb/tb_pcie_dllp_sched.sv
// Self-checking bench for pcie_dllp_sched: table-driven Ack coalescing vectors plus
// hand-written Nak, arbitration, UpdateFC refresh, link-down and reset sequences.
module tb_pcie_dllp_sched;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        dl_active, tlp_good, tlp_bad, ready;
  logic [11:0] tlp_seq;
  logic [2:0]  fc_upd_req;
  logic [23:0] fc_hdr;
  logic [35:0] fc_data;
  logic        valid;
  logic [7:0]  dtype;
  logic [23:0] payload;

  logic        f_valid;
  logic [7:0]  f_type;
  logic [23:0] f_payload;

  int cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pcie_dllp_sched dut (
    .clk(clk), .rst_n(rst_n), .dl_active_i(dl_active),
    .tlp_good_i(tlp_good), .tlp_seq_i(tlp_seq), .tlp_bad_i(tlp_bad),
    .fc_upd_req_i(fc_upd_req), .fc_hdr_i(fc_hdr), .fc_data_i(fc_data),
    .dllp_valid_o(valid), .dllp_ready_i(ready),
    .dllp_type_o(dtype), .dllp_payload_o(payload)
  );

  pcie_dllp_sched #(.FC_TIMER_MAX(16)) dut_fc (
    .clk(clk), .rst_n(rst_n), .dl_active_i(1'b1),
    .tlp_good_i(1'b0), .tlp_seq_i(12'h000), .tlp_bad_i(1'b0),
    .fc_upd_req_i(3'b000), .fc_hdr_i(24'h000020), .fc_data_i(36'h000000080),
    .dllp_valid_o(f_valid), .dllp_ready_i(1'b1),
    .dllp_type_o(f_type), .dllp_payload_o(f_payload)
  );

  typedef struct {
    logic [7:0]  typ;
    logic [23:0] pay;
    int          cyc;
  } exp_t;

  typedef struct {
    int          n;
    logic [11:0] seq0;
    logic [23:0] pay0;
    int          lat0;
    bit          two;
    logic [23:0] pay1;
    int          lat1;
  } ack_vec_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  bit   fc_rec = 1'b0;
  int   fc_cyc_q[$];
  logic [23:0] fc_pay_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] t, input logic [23:0] p, input int c);
    exp_t e;
    e.typ = t;
    e.pay = p;
    e.cyc = c;
    sb_q.push_back(e);
  endtask

  task automatic wait_drain(input int max_cyc);
    int k = 0;
    while (sb_q.size() != 0 && k < max_cyc) begin
      step();
      k++;
    end
    check("drain_pending", 32'(sb_q.size()), 32'd0);
    sb_q.delete();
  endtask

  task automatic idle_reset();
    dl_active = 1'b0;
    step();
    step();
    dl_active = 1'b1;
  endtask

  // Scoreboard monitor: a handshake is visible at the negedge before the accepting edge.
  initial begin
    int   start_cyc;
    bit   in_flight;
    exp_t e;
    start_cyc = 0;
    in_flight = 1'b0;
    forever begin
      @(negedge clk);
      if (!valid) begin
        in_flight = 1'b0;
      end else begin
        if (!in_flight) begin
          start_cyc = cyc;
          in_flight = 1'b1;
        end
        if (ready) begin
          if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_dllp: got type=%02h payload=%06h, expected no DLLP (cycle %0d)",
                     dtype, payload, cyc);
          end else begin
            e = sb_q.pop_front();
            check("dllp_type", 32'(dtype), 32'(e.typ));
            check("dllp_payload", 32'(payload), 32'(e.pay));
            if (e.cyc >= 0) check("dllp_start_cycle", 32'(start_cyc), 32'(e.cyc));
          end
          in_flight = 1'b0;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (fc_rec && f_valid && f_type == 8'h80) begin
        fc_cyc_q.push_back(cyc);
        fc_pay_q.push_back(f_payload);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    ack_vec_t vecs[6];
    int       c0;
    int       c1;
    int       c2;

    vecs[0] = '{n: 4, seq0: 12'd0,    pay0: 24'h000003, lat0: 4,  two: 1'b0, pay1: 24'h0,      lat1: 0};
    vecs[1] = '{n: 1, seq0: 12'd7,    pay0: 24'h000007, lat0: 64, two: 1'b0, pay1: 24'h0,      lat1: 0};
    vecs[2] = '{n: 4, seq0: 12'd4094, pay0: 24'h000001, lat0: 4,  two: 1'b0, pay1: 24'h0,      lat1: 0};
    vecs[3] = '{n: 2, seq0: 12'd100,  pay0: 24'h000065, lat0: 64, two: 1'b0, pay1: 24'h0,      lat1: 0};
    vecs[4] = '{n: 6, seq0: 12'd10,   pay0: 24'h00000D, lat0: 4,  two: 1'b1, pay1: 24'h00000F, lat1: 68};
    vecs[5] = '{n: 3, seq0: 12'd4095, pay0: 24'h000001, lat0: 64, two: 1'b0, pay1: 24'h0,      lat1: 0};

    rst_n      = 1'b0;
    dl_active  = 1'b1;
    tlp_good   = 1'b0;
    tlp_bad    = 1'b0;
    tlp_seq    = 12'h000;
    fc_upd_req = 3'b000;
    fc_hdr     = {8'h33, 8'h22, 8'h11};
    fc_data    = {12'h333, 12'h222, 12'h111};
    ready      = 1'b1;

    #2;
    check("reset_valid", 32'(valid), 32'd0);
    check("reset_type", 32'(dtype), 32'd0);
    check("reset_payload", 32'(payload), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_valid", 32'(valid), 32'd0);

    // Periodic UpdateFC on the short-period instance.
    fc_rec = 1'b1;
    repeat (100) step();
    fc_rec = 1'b0;
    check("fc_p_count_ge6", 32'(fc_cyc_q.size() >= 6), 32'd1);
    for (int i = 0; i < fc_cyc_q.size(); i++) begin
      check("fc_p_payload", 32'(fc_pay_q[i]), 32'h080080);
      if (i > 0) check("fc_p_period", 32'(fc_cyc_q[i] - fc_cyc_q[i-1]), 32'd16);
    end

    // Ack coalescing / timer vectors.
    for (int v = 0; v < 6; v++) begin
      idle_reset();
      step();
      c0 = cyc;
      push(8'h00, vecs[v].pay0, c0 + 1 + vecs[v].lat0);
      if (vecs[v].two) push(8'h00, vecs[v].pay1, c0 + 1 + vecs[v].lat1);
      for (int k = 0; k < vecs[v].n; k++) begin
        tlp_good = 1'b1;
        tlp_seq  = vecs[v].seq0 + 12'(k);
        step();
      end
      tlp_good = 1'b0;
      wait_drain(150);
      repeat (70) step();
    end

    // One Nak per error episode; a good TLP re-arms it.
    idle_reset();
    step();
    c0 = cyc;
    tlp_good = 1'b1;
    tlp_seq  = 12'd5;
    push(8'h10, 24'h000005, c0 + 3);
    step();
    tlp_good = 1'b0;
    tlp_bad  = 1'b1;
    repeat (3) step();
    tlp_bad = 1'b0;
    wait_drain(20);
    repeat (80) step();
    c0 = cyc;
    tlp_good = 1'b1;
    tlp_seq  = 12'd6;
    push(8'h10, 24'h000006, c0 + 3);
    step();
    tlp_good = 1'b0;
    tlp_bad  = 1'b1;
    step();
    tlp_bad = 1'b0;
    wait_drain(20);
    repeat (80) step();

    // Priority with everything pending behind a stalled link.
    idle_reset();
    ready = 1'b0;
    step();
    c1 = cyc;
    fc_upd_req = 3'b001;
    push(8'h80, 24'h044111, c1 + 2);
    step();
    fc_upd_req = 3'b000;
    for (int k = 0; k < 4; k++) begin
      tlp_good = 1'b1;
      tlp_seq  = 12'(k);
      step();
    end
    tlp_good   = 1'b0;
    tlp_bad    = 1'b1;
    fc_upd_req = 3'b111;
    step();
    tlp_bad    = 1'b0;
    fc_upd_req = 3'b000;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("stall_valid", 32'(valid), 32'd1);
      check("stall_type", 32'(dtype), 32'h80);
      check("stall_payload", 32'(payload), 32'h044111);
    end
    step();
    c2 = cyc;
    ready = 1'b1;
    push(8'h10, 24'h000003, c2 + 1);
    push(8'h80, 24'h044111, c2 + 2);
    push(8'h90, 24'h088222, c2 + 3);
    push(8'hA0, 24'h0CC333, c2 + 4);
    wait_drain(20);
    repeat (80) step();

    // Link down: held DLLP completes, nothing else is sent.
    idle_reset();
    ready = 1'b0;
    step();
    c1 = cyc;
    fc_upd_req = 3'b001;
    push(8'h80, 24'h044111, c1 + 2);
    step();
    fc_upd_req = 3'b000;
    for (int k = 0; k < 4; k++) begin
      tlp_good = 1'b1;
      tlp_seq  = 12'(20 + k);
      step();
    end
    tlp_good  = 1'b0;
    dl_active = 1'b0;
    step();
    fc_upd_req = 3'b010;
    step();
    fc_upd_req = 3'b000;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("linkdown_held_valid", 32'(valid), 32'd1);
      check("linkdown_held_type", 32'(dtype), 32'h80);
    end
    step();
    ready = 1'b1;
    wait_drain(5);
    repeat (5) step();
    dl_active = 1'b1;
    @(negedge clk);
    check("linkdown_idle_valid", 32'(valid), 32'd0);
    repeat (80) step();

    // Reset while a DLLP is held.
    ready = 1'b0;
    step();
    fc_upd_req = 3'b001;
    step();
    fc_upd_req = 3'b000;
    step();
    step();
    @(negedge clk);
    check("pre_reset_held_valid", 32'(valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_valid", 32'(valid), 32'd0);
    check("async_reset_type", 32'(dtype), 32'd0);
    check("async_reset_payload", 32'(payload), 32'd0);
    step();
    step();
    rst_n = 1'b1;
    ready = 1'b1;
    step();
    c0 = cyc;
    tlp_bad = 1'b1;
    push(8'h10, 24'h000FFF, c0 + 2);
    step();
    tlp_bad = 1'b0;
    wait_drain(20);
    repeat (10) step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
